// File: rtl/fft_pkg.sv
// Shared definitions for the R2^2 SDF FFT pipeline stages.
// Optional build macro: FFT_BF_SCALE_EN -- butterfly outputs scaled by 1/2,
// which removes the one bit of per-stage output growth.
package fft_pkg;

    // Butterfly flavours selectable on fft_r22sdf_bf_stage
    localparam int BF_TYPE_I  = 1;
    localparam int BF_TYPE_II = 2;

    // Delay lines longer than this are built as a RAM/SRL circular buffer
    localparam int SRL_THRESH_DEFAULT = 32;

    // Output growth of a butterfly stage: one bit unless outputs are halved
`ifdef FFT_BF_SCALE_EN
    localparam int BF_OUT_GROWTH = 0;
`else
    localparam int BF_OUT_GROWTH = 1;
`endif

    // Ceiling log2, usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_sdf_delay.sv
// Clock-enabled feedback delay line of LEN entries for an SDF butterfly.
// Short lines are a resettable register array; long lines are a circular
// buffer in plain memory whose contents read as zero until it has been
// completely rewritten after reset, so the memory itself needs no reset.
module fft_sdf_delay
    import fft_pkg::*;
#(
    parameter int WIDTH      = 26,
    parameter int LEN        = 512,
    parameter int SRL_THRESH = SRL_THRESH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             ce_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam bit USE_MEM = (LEN > SRL_THRESH) && (LEN >= 2);
    localparam int PW      = (clog2(LEN) > 0) ? clog2(LEN) : 1;

    generate
        if (USE_MEM) begin : g_mem
            logic [WIDTH-1:0] mem [LEN];
            logic [PW-1:0]    ptr;
            logic [PW:0]      fill;
            logic             filled;

            // Memory write port; kept free of reset so it maps onto RAM/SRL
            always_ff @(posedge clk_i) begin
                if (rst_n && ce_i) begin
                    mem[ptr] <= din_i;
                end
            end

            // Pointer walks the buffer; fill counts writes until every entry is fresh
            always_ff @(posedge clk_i) begin
                if (!rst_n) begin
                    ptr  <= '0;
                    fill <= '0;
                end else if (ce_i) begin
                    ptr <= ptr + PW'(1);
                    if (!filled) begin
                        fill <= fill + (PW + 1)'(1);
                    end
                end
            end

            assign filled = (fill == (PW + 1)'(LEN));
            assign dout_o = filled ? mem[ptr] : '0;
        end else begin : g_reg
            logic [WIDTH-1:0] sr [LEN];

            // Plain shift register, cleared on reset, shifting on each enabled cycle
            always_ff @(posedge clk_i) begin
                if (!rst_n) begin
                    for (int i = 0; i < LEN; i++) begin
                        sr[i] <= '0;
                    end
                end else if (ce_i) begin
                    sr[0] <= din_i;
                    for (int i = 1; i < LEN; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout_o = sr[LEN-1];
        end
    endgenerate

endmodule

// File: rtl/fft_r22sdf_bf_stage.sv
// R2^2 SDF butterfly stage. BF_TYPE selects BF-I (plain butterfly) or BF-II
// (butterfly with a trivial -j rotation on the last quarter of each block).
// The stage owns its control counter; sync_i realigns it to a frame start.
// Optional build macro: FFT_BF_SCALE_EN -- outputs are (value+1)>>>1 and
// DATA_WIDTH bits wide instead of DATA_WIDTH+1; the delay line keeps full width.
module fft_r22sdf_bf_stage
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH    = 25,
    parameter int SHIFT_REG_LEN = 512,
    parameter int BF_TYPE       = BF_TYPE_I,
    parameter int SRL_THRESH    = SRL_THRESH_DEFAULT
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n,
    input  logic                                       valid_i,
    input  logic                                       sync_i,
    input  logic signed [DATA_WIDTH-1:0]               x_re_i,
    input  logic signed [DATA_WIDTH-1:0]               x_im_i,
    output logic                                       valid_o,
    output logic                                       sync_o,
    output logic signed [DATA_WIDTH+BF_OUT_GROWTH-1:0] z_re_o,
    output logic signed [DATA_WIDTH+BF_OUT_GROWTH-1:0] z_im_o
);

    localparam int LB = clog2(SHIFT_REG_LEN);
    localparam int CW = LB + 2;
    localparam int IW = DATA_WIDTH + 1;
    localparam int OW = DATA_WIDTH + BF_OUT_GROWTH;
    localparam logic [CW-1:0] SYNC_CNT = CW'(SHIFT_REG_LEN);

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_eff;
    logic                 primed;
    logic                 sel;
    logic                 rot;
    logic signed [IW-1:0] x_re_ext, x_im_ext;
    logic signed [IW-1:0] xr_re, xr_im;
    logic signed [IW-1:0] d_re, d_im;
    logic signed [IW-1:0] sum_re, sum_im;
    logic signed [IW-1:0] dif_re, dif_im;
    logic signed [IW-1:0] out_re, out_im;
    logic signed [IW-1:0] dl_in_re, dl_in_im;
    logic signed [OW-1:0] z_re_next, z_im_next;

    // Control decode, optional -j rotation and the butterfly itself
    always_comb begin
        cnt_eff  = sync_i ? '0 : cnt;
        sel      = cnt_eff[LB];
        rot      = (BF_TYPE == BF_TYPE_II) && cnt_eff[LB] && cnt_eff[LB+1];
        x_re_ext = {x_re_i[DATA_WIDTH-1], x_re_i};
        x_im_ext = {x_im_i[DATA_WIDTH-1], x_im_i};
        xr_re    = x_re_ext;
        xr_im    = x_im_ext;
        if (rot) begin
            xr_re = x_im_ext;
            xr_im = -x_re_ext;
        end
        sum_re   = xr_re + d_re;
        sum_im   = xr_im + d_im;
        dif_re   = d_re - xr_re;
        dif_im   = d_im - xr_im;
        out_re   = d_re;
        out_im   = d_im;
        dl_in_re = xr_re;
        dl_in_im = xr_im;
        if (sel) begin
            out_re   = sum_re;
            out_im   = sum_im;
            dl_in_re = dif_re;
            dl_in_im = dif_im;
        end
    end

`ifdef FFT_BF_SCALE_EN
    logic signed [IW:0] rnd_re, rnd_im;

    // Halve the output with round-half-up, using one guard bit for the +1
    always_comb begin
        rnd_re    = {out_re[IW-1], out_re} + {{IW{1'b0}}, 1'b1};
        rnd_im    = {out_im[IW-1], out_im} + {{IW{1'b0}}, 1'b1};
        z_re_next = rnd_re[OW:1];
        z_im_next = rnd_im[OW:1];
    end
`else
    // Full-precision output path
    always_comb begin
        z_re_next = out_re;
        z_im_next = out_im;
    end
`endif

    // Control counter and primed flag advance only on valid samples
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (valid_i) begin
            cnt    <= cnt_eff + CW'(1);
            primed <= primed | sel;
        end
    end

    // Output registers: flags follow valid_i each clock, data loads on valid samples
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            sync_o  <= 1'b0;
            z_re_o  <= '0;
            z_im_o  <= '0;
        end else begin
            valid_o <= valid_i & (primed | sel);
            sync_o  <= valid_i & (cnt_eff == SYNC_CNT);
            if (valid_i) begin
                z_re_o <= z_re_next;
                z_im_o <= z_im_next;
            end
        end
    end

    fft_sdf_delay #(
        .WIDTH      (IW),
        .LEN        (SHIFT_REG_LEN),
        .SRL_THRESH (SRL_THRESH)
    ) u_delay_re (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .ce_i   (valid_i),
        .din_i  (dl_in_re),
        .dout_o (d_re)
    );

    fft_sdf_delay #(
        .WIDTH      (IW),
        .LEN        (SHIFT_REG_LEN),
        .SRL_THRESH (SRL_THRESH)
    ) u_delay_im (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .ce_i   (valid_i),
        .din_i  (dl_in_im),
        .dout_o (d_im)
    );

endmodule

// File: tb/tb_fft_r22sdf_bf_stage.sv
// Directed testbench for fft_r22sdf_bf_stage. Three instances share the input
// stream: BF-I with L=2 (register delay), BF-II with L=1, and BF-I with L=4
// forced onto the memory delay line. Expected values are hand-computed in
// full precision and halved by sc() when FFT_BF_SCALE_EN is defined.
module tb_fft_r22sdf_bf_stage;
    import fft_pkg::*;

    localparam int DW = 8;
`ifdef FFT_BF_SCALE_EN
    localparam int OW = DW;
`else
    localparam int OW = DW + 1;
`endif

    typedef struct {
        bit sy;
        int xr;
        int xi;
        bit ev;
        bit es;
        int er;
        int ei;
    } vec_t;

    logic                 clk_i = 1'b0;
    logic                 rst_n;
    logic                 valid_i;
    logic                 sync_i;
    logic signed [DW-1:0] x_re_i, x_im_i;

    logic                 valid_a, sync_a, valid_b, sync_b, valid_c, sync_c;
    logic signed [OW-1:0] z_re_a, z_im_a, z_re_b, z_im_b, z_re_c, z_im_c;

    int   checks = 0;
    int   errors = 0;
    vec_t tab[$];

    always #5 clk_i = ~clk_i;

    fft_r22sdf_bf_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(2), .BF_TYPE(BF_TYPE_I), .SRL_THRESH(32)) dut_a (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .sync_i(sync_i),
        .x_re_i(x_re_i), .x_im_i(x_im_i),
        .valid_o(valid_a), .sync_o(sync_a), .z_re_o(z_re_a), .z_im_o(z_im_a));

    fft_r22sdf_bf_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(1), .BF_TYPE(BF_TYPE_II), .SRL_THRESH(32)) dut_b (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .sync_i(sync_i),
        .x_re_i(x_re_i), .x_im_i(x_im_i),
        .valid_o(valid_b), .sync_o(sync_b), .z_re_o(z_re_b), .z_im_o(z_im_b));

    fft_r22sdf_bf_stage #(.DATA_WIDTH(DW), .SHIFT_REG_LEN(4), .BF_TYPE(BF_TYPE_I), .SRL_THRESH(2)) dut_c (
        .clk_i(clk_i), .rst_n(rst_n), .valid_i(valid_i), .sync_i(sync_i),
        .x_re_i(x_re_i), .x_im_i(x_im_i),
        .valid_o(valid_c), .sync_o(sync_c), .z_re_o(z_re_c), .z_im_o(z_im_c));

    // Full-precision expected value mapped onto the output format
    function automatic int sc(input int v);
        logic signed [OW-1:0] t;
`ifdef FFT_BF_SCALE_EN
        t = OW'((v + 1) >>> 1);
`else
        t = OW'(v);
`endif
        return int'(t);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input bit s, input int xr, input int xi);
        @(negedge clk_i);
        valid_i = v;
        sync_i  = s;
        x_re_i  = DW'(xr);
        x_im_i  = DW'(xi);
        @(posedge clk_i);
        #1;
    endtask

    task automatic sampleDut(input int which, output logic v, output logic s,
                             output logic signed [31:0] re, output logic signed [31:0] im);
        case (which)
            0:       begin v = valid_a; s = sync_a; re = z_re_a; im = z_im_a; end
            1:       begin v = valid_b; s = sync_b; re = z_re_b; im = z_im_b; end
            default: begin v = valid_c; s = sync_c; re = z_re_c; im = z_im_c; end
        endcase
    endtask

    task automatic addVec(input bit sy, input int xr, input int xi,
                          input bit ev, input bit es, input int er, input int ei);
        vec_t t;
        t.sy = sy; t.xr = xr; t.xi = xi;
        t.ev = ev; t.es = es; t.er = er; t.ei = ei;
        tab.push_back(t);
    endtask

    // Hold reset for some cycles (optionally with live input), check cleared outputs
    task automatic applyReset(input int cycles, input bit busy);
        logic v, s;
        logic signed [31:0] re, im;
        @(negedge clk_i);
        rst_n   = 1'b0;
        valid_i = busy;
        sync_i  = 1'b0;
        x_re_i  = busy ? DW'(50) : '0;
        x_im_i  = busy ? DW'(-50) : '0;
        repeat (cycles) @(posedge clk_i);
        #1;
        for (int w = 0; w < 3; w++) begin
            sampleDut(w, v, s, re, im);
            checkOutput($sformatf("reset.dut%0d.valid", w), v, 0);
            checkOutput($sformatf("reset.dut%0d.sync", w), s, 0);
            checkOutput($sformatf("reset.dut%0d.re", w), re, 0);
            checkOutput($sformatf("reset.dut%0d.im", w), im, 0);
        end
        @(negedge clk_i);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        sync_i  = 1'b0;
        x_re_i  = '0;
        x_im_i  = '0;
    endtask

    // Play the vector table into the stream and check one instance per sample
    task automatic runVectors(input string name, input int which, input bit gaps);
        logic v, s;
        logic signed [31:0] re, im;
        foreach (tab[i]) begin
            applyStimulus(1'b1, tab[i].sy, tab[i].xr, tab[i].xi);
            sampleDut(which, v, s, re, im);
            checkOutput($sformatf("%s[%0d].valid", name, i), v, int'(tab[i].ev));
            checkOutput($sformatf("%s[%0d].sync", name, i), s, int'(tab[i].es));
            checkOutput($sformatf("%s[%0d].re", name, i), re, sc(tab[i].er));
            checkOutput($sformatf("%s[%0d].im", name, i), im, sc(tab[i].ei));
            if (gaps) begin
                applyStimulus(1'b0, 1'b1, 55, -55);
                sampleDut(which, v, s, re, im);
                checkOutput($sformatf("%s[%0d].gap_valid", name, i), v, 0);
                checkOutput($sformatf("%s[%0d].gap_sync", name, i), s, 0);
                checkOutput($sformatf("%s[%0d].gap_re", name, i), re, sc(tab[i].er));
                checkOutput($sformatf("%s[%0d].gap_im", name, i), im, sc(tab[i].ei));
            end
        end
        tab.delete();
    endtask

    // BF-I, L=2 frame 1,2,3,4 followed by two flush samples
    task automatic loadFrameA();
        addVec(1, 1, 0, 0, 0,  0, 0);
        addVec(0, 2, 0, 0, 0,  0, 0);
        addVec(0, 3, 0, 1, 1,  4, 0);
        addVec(0, 4, 0, 1, 0,  6, 0);
        addVec(0, 0, 0, 1, 0, -2, 0);
        addVec(0, 0, 0, 1, 0, -2, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        sync_i  = 1'b0;
        x_re_i  = '0;
        x_im_i  = '0;
        applyReset(2, 1'b0);

        loadFrameA();
        runVectors("bf1", 0, 1'b0);

        applyReset(1, 1'b0);
        loadFrameA();
        runVectors("bf1_gap", 0, 1'b1);

        applyReset(1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1, 0);
        applyStimulus(1'b1, 1'b0, 2, 0);
        applyStimulus(1'b1, 1'b0, 3, 0);
        applyReset(2, 1'b1);
        loadFrameA();
        runVectors("bf1_restart", 0, 1'b0);

        applyReset(1, 1'b0);
        addVec(1, 1, 0, 0, 0,  0,  0);
        addVec(0, 2, 0, 1, 1,  3,  0);
        addVec(0, 3, 0, 1, 0, -1,  0);
        addVec(0, 4, 0, 1, 0,  3, -4);
        addVec(0, 0, 0, 1, 0,  3,  4);
        runVectors("bf2", 1, 1'b0);

        applyReset(1, 1'b0);
        addVec(1,    0, 0, 0, 0, 0,    0);
        addVec(0,    0, 0, 1, 1, 0,    0);
        addVec(0,    0, 0, 1, 0, 0,    0);
        addVec(0, -128, 0, 1, 0, 0,  128);
        addVec(0,    0, 0, 1, 0, 0, -128);
        runVectors("bf2_negmax", 1, 1'b0);

        applyReset(1, 1'b0);
        addVec(1, -128,  127, 0, 0,    0,   0);
        addVec(0,    0,    0, 0, 0,    0,   0);
        addVec(0, -128, -127, 1, 1, -256,   0);
        addVec(0,    0,    0, 1, 0,    0,   0);
        addVec(0,    0,    0, 1, 0,    0, 254);
        addVec(0,    0,    0, 1, 0,    0,   0);
        runVectors("bf1_extreme", 0, 1'b0);

        applyReset(1, 1'b0);
        addVec(1,  1, 0, 0, 0,  0, 0);
        addVec(0,  2, 0, 0, 0,  0, 0);
        addVec(0,  3, 0, 0, 0,  0, 0);
        addVec(0,  4, 0, 0, 0,  0, 0);
        addVec(0,  5, 0, 1, 1,  6, 0);
        addVec(0,  6, 0, 1, 0,  8, 0);
        addVec(1,  7, 0, 1, 0,  3, 0);
        addVec(0,  8, 0, 1, 0,  4, 0);
        addVec(0,  9, 0, 1, 0, -4, 0);
        addVec(0, 10, 0, 1, 0, -4, 0);
        addVec(0, 11, 0, 1, 1, 18, 0);
        runVectors("resync", 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
